// File: rtl/tof_sequencer.sv
// Single-ping sonar sequencer: burst, blanking, listen, time-of-flight capture via an external event counter.
// Define TOF_ECHO_DEBOUNCE_EN to require ECHO_HOLD consecutive synchronized echo samples before a hit.
module tof_sequencer #(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned BURST_CYCLES   = 400,
  parameter int unsigned BLANK_CYCLES   = 4000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned ECHO_HOLD      = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic                   echo_in,
  input  logic [COUNT_WIDTH-1:0] count_in,
  output logic                   counter_clr_out,
  output logic                   count_en_out,
  output logic                   burst_out,
  output logic                   busy_out,
  output logic [COUNT_WIDTH-1:0] tof_out,
  output logic                   tof_valid_out,
  output logic                   timeout_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_BURST, S_BLANK, S_LISTEN, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic                   hit_q, hit_d;
  logic [COUNT_WIDTH-1:0] tof_q, tof_d;
  logic                   echo_s;
  logic                   qualify;
  logic                   at_timeout;
  logic [COUNT_WIDTH-1:0] cand_now;

  assign echo_s     = sync2_q;
  assign at_timeout = (count_in == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
  // Two cycles of synchronizer delay separate the raw edge from the count it is seen at.
  assign cand_now   = count_in - COUNT_WIDTH'(2);

`ifdef TOF_ECHO_DEBOUNCE_EN
  localparam int unsigned RUN_W = $clog2(ECHO_HOLD + 1);
  logic [RUN_W-1:0]       run_q, run_d, run_inc;
  logic [COUNT_WIDTH-1:0] cand_q, cand_d;

  assign run_inc = run_q + RUN_W'(1);
  assign qualify = (state_q == S_LISTEN) && echo_s && (run_inc == RUN_W'(ECHO_HOLD));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_q  <= '0;
      cand_q <= '0;
    end else begin
      run_q  <= run_d;
      cand_q <= cand_d;
    end
  end

  always_comb begin
    run_d  = '0;
    cand_d = cand_q;
    if (state_q == S_LISTEN && echo_s) begin
      run_d = run_inc;
      if (run_q == '0) cand_d = cand_now;
    end
  end
`else
  assign qualify = (state_q == S_LISTEN) && echo_s;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hit_q   <= 1'b0;
      tof_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= echo_in;
      sync2_q <= sync1_q;
      hit_q   <= hit_d;
      tof_q   <= tof_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    tof_d   = tof_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_BURST;
      S_BURST: if (count_in == COUNT_WIDTH'(BURST_CYCLES - 1)) state_d = S_BLANK;
      S_BLANK: if (count_in == COUNT_WIDTH'(BLANK_CYCLES - 1)) state_d = S_LISTEN;
      S_LISTEN: begin
        // A qualifying echo takes priority over a simultaneous timeout.
        if (qualify) begin
`ifdef TOF_ECHO_DEBOUNCE_EN
          tof_d = (run_q == '0) ? cand_now : cand_q;
`else
          tof_d = cand_now;
`endif
          hit_d   = 1'b1;
          state_d = S_DONE;
        end else if (at_timeout) begin
          hit_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign counter_clr_out = (state_q == S_IDLE) || (state_q == S_DONE);
  assign count_en_out    = (state_q == S_BURST) || (state_q == S_BLANK) || (state_q == S_LISTEN);
  assign burst_out       = (state_q == S_BURST);
  assign busy_out        = (state_q != S_IDLE);
  assign tof_valid_out   = (state_q == S_DONE) && hit_q;
  assign timeout_out     = (state_q == S_DONE) && !hit_q;
  assign tof_out         = tof_q;

endmodule

// File: tb/tb_tof_sequencer.sv
// Bench for tof_sequencer: attaches a counter model, drives echo waveforms indexed by ping count
// and compares each ping against a window-search reference model.
module tb_tof_sequencer;
  localparam int W     = 32;
  localparam int BURST = 4;
  localparam int BLANK = 10;
  localparam int TMO   = 50;
  localparam int HOLD  = 3;
`ifdef TOF_ECHO_DEBOUNCE_EN
  localparam int QUAL = HOLD;
`else
  localparam int QUAL = 1;
`endif

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         start_in;
  logic         echo_in;
  logic [W-1:0] cnt;
  logic         counter_clr_out, count_en_out, burst_out, busy_out;
  logic [W-1:0] tof_out;
  logic         tof_valid_out, timeout_out;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] tof_exp;
  logic [63:0]  ones;

  tof_sequencer #(
    .COUNT_WIDTH(W), .BURST_CYCLES(BURST), .BLANK_CYCLES(BLANK),
    .TIMEOUT_CYCLES(TMO), .ECHO_HOLD(HOLD)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .echo_in(echo_in),
    .count_in(cnt), .counter_clr_out(counter_clr_out), .count_en_out(count_en_out),
    .burst_out(burst_out), .busy_out(busy_out), .tof_out(tof_out),
    .tof_valid_out(tof_valid_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // External event counter: clear dominates, otherwise counts enabled cycles.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)               cnt <= '0;
    else if (counter_clr_out) cnt <= '0;
    else if (count_en_out)    cnt <= cnt + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // raw[k] is the echo level driven during the cycle whose count is k; the synchronized
  // echo at count k is raw[k-2]. A hit is the first count k in the listen window where the
  // last QUAL synchronized samples are all high and all inside the window.
  function automatic void ref_ping(input logic [63:0] raw, output bit hit, output int kd,
                                   output int tof);
    bit all;
    hit = 1'b0;
    kd  = TMO - 1;
    tof = 0;
    for (int k = BLANK + QUAL - 1; k <= TMO - 1; k++) begin
      if (!hit) begin
        all = 1'b1;
        for (int j = k - QUAL + 1; j <= k; j++) if (!raw[j-2]) all = 1'b0;
        if (all) begin
          hit = 1'b1;
          kd  = k;
          tof = k - QUAL + 1 - 2;
        end
      end
    end
  endfunction

  task automatic do_ping(input logic [63:0] raw, input bit hold, input string tag);
    bit hit, done;
    int kd, tof_m, cyc, bursts, busy_n, vld_n, to_n, done_cyc, n;
    ref_ping(raw, hit, kd, tof_m);
    done = 1'b0; cyc = 0; bursts = 0; busy_n = 0; vld_n = 0; to_n = 0; done_cyc = -1;
    @(negedge clk_in);
    start_in = 1'b1;
    echo_in  = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      if (!hold) start_in = 1'b0;
      if (burst_out) bursts++;
      if (busy_out) busy_n++;
      if (tof_valid_out) vld_n++;
      if (timeout_out) to_n++;
      if (tof_valid_out || timeout_out) begin
        done = 1'b1;
        done_cyc = cyc;
      end
      echo_in = (busy_out && !done && cnt < 64) ? raw[cnt[5:0]] : 1'b0;
    end
    echo_in = 1'b0;
    if (hit) tof_exp = W'(tof_m);
    check({tag, " done_seen"}, W'(done), 1);
    check({tag, " done_cycle"}, done_cyc, kd + 2);
    check({tag, " burst_len"}, bursts, BURST);
    check({tag, " busy_len"}, busy_n, kd + 2);
    check({tag, " valid_pulses"}, vld_n, W'(hit));
    check({tag, " timeout_pulses"}, to_n, W'(!hit));
    check({tag, " tof"}, tof_out, tof_exp);
    @(negedge clk_in);
    check({tag, " idle_busy"}, W'(busy_out), 0);
    check({tag, " idle_clr"}, W'(counter_clr_out), 1);
    if (hold) begin
      @(negedge clk_in);
      check({tag, " rearm_burst"}, W'(burst_out), 1);
      start_in = 1'b0;
      n = 0;
      while (busy_out && n < 200) begin
        @(negedge clk_in);
        n++;
      end
      check({tag, " rearm_ends"}, W'(busy_out), 0);
    end
  endtask

  initial begin
    logic [63:0] raw;
    int mode;
    ones     = '1;
    tof_exp  = '0;
    rst_in   = 1'b1;
    start_in = 1'b0;
    echo_in  = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_clr", W'(counter_clr_out), 1);
    check("rst_en", W'(count_en_out), 0);
    check("rst_burst", W'(burst_out), 0);
    check("rst_busy", W'(busy_out), 0);
    check("rst_valid", W'(tof_valid_out), 0);
    check("rst_timeout", W'(timeout_out), 0);
    check("rst_tof", tof_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    do_ping(ones << 18, 1'b0, "clean_hit");
    check("clean_hit_const", tof_out, 18);

    do_ping(64'd0, 1'b0, "timeout");
    check("timeout_keeps_tof", tof_out, 18);

    raw = (64'h1F << 3) | (64'h3 << 18) | (ones << 28);
    do_ping(raw, 1'b0, "glitch_blank");
`ifdef TOF_ECHO_DEBOUNCE_EN
    check("glitch_blank_const", tof_out, 28);
`else
    check("glitch_blank_const", tof_out, 18);
`endif

    do_ping(ones << 45, 1'b0, "tie");

    do_ping(64'd1 << 23, 1'b0, "single_sample");

    do_ping(ones << 20, 1'b1, "held_start");

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       raw = 64'd0;
        1:       raw = ones << $urandom_range(0, 55);
        2:       raw = {$urandom, $urandom};
        default: raw = {$urandom, $urandom} | {$urandom, $urandom};
      endcase
      do_ping(raw, 1'b0, $sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of a burst.
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("pre_rst_burst", W'(burst_out), 1);
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_burst", W'(burst_out), 0);
    check("async_rst_clr", W'(counter_clr_out), 1);
    check("async_rst_busy", W'(busy_out), 0);
    check("async_rst_tof", tof_out, 0);
    tof_exp = '0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    do_ping(ones << 18, 1'b0, "post_reset");
    check("post_reset_const", tof_out, 18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
